// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
// shared-ALU datapath and a unified memory over a req/ready handshake.
// Unsupported encodings and memory stalls that last too long stop the
// controller in TRAP until reset. Retired instructions are counted in instret.
// Control outputs are combinational from state and the IR fields. While reset
// is held low they are forced to their reset values.
module mips_mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctr,
  output logic [1:0]       ext_ctr,
  output logic [1:0]       npc_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             trap,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] instret
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL  = 4'd0,
    C_RALU = 4'd1,
    C_JR   = 4'd2,
    C_ORI  = 4'd3,
    C_LUI  = 4'd4,
    C_LW   = 4'd5,
    C_SW   = 4'd6,
    C_BEQ  = 4'd7,
    C_J    = 4'd8,
    C_JAL  = 4'd9
  } iclass_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_PASS = 4'b0101;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  // Classify the instruction held in IR. Anything not listed is illegal.
  function automatic iclass_t decode_class(input logic [5:0] o, input logic [5:0] f);
    iclass_t c;
    c = C_ILL;
    case (o)
      6'b000000: begin
        case (f)
          6'b100001, 6'b100011, 6'b100100,
          6'b100101, 6'b101010: c = C_RALU;
          6'b001000:            c = C_JR;
          default:              c = C_ILL;
        endcase
      end
      6'b001101: c = C_ORI;
      6'b001111: c = C_LUI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // ALU operation for the supported R-type ALU functions.
  function automatic logic [3:0] r_alu_op(input logic [5:0] f);
    logic [3:0] a;
    case (f)
      6'b100001: a = ALU_ADD;
      6'b100011: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      default:   a = ALU_ADD;
    endcase
    return a;
  endfunction

  state_t           state;
  state_t           next_state;
  iclass_t          iclass;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       cause_reg;
  logic             retire;
  logic             set_ill;
  logic             set_tmo;
  logic             mem_wait;
  logic             tmo_last;
  logic             mem_entry;

  // IR is stable from DECODE onward, so the class can be decoded every cycle.
  assign iclass = decode_class(op, func);

  // A memory-facing state that is still waiting for its acknowledge.
  assign mem_wait  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  // One more unacknowledged cycle reaches the timeout limit.
  assign tmo_last  = mem_wait && (tmo_cnt >= TMO_W'(MEM_TIMEOUT - 1));
  // Entering a memory-facing state restarts the wait budget.
  assign mem_entry = (next_state != state) &&
                     ((next_state == S_FETCH) || (next_state == S_MEM));

  assign cause = cause_reg;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, retire and trap-cause selection.
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    set_ill    = 1'b0;
    set_tmo    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (tmo_last) begin
          next_state = S_TRAP;
          set_tmo    = 1'b1;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (iclass == C_ILL) begin
          next_state = S_TRAP;
          set_ill    = 1'b1;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (iclass)
          C_RALU, C_ORI, C_LUI: next_state = S_WB;
          C_LW, C_SW:           next_state = S_MEM;
          C_BEQ, C_J, C_JAL, C_JR: begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          default: begin
            next_state = S_TRAP;
            set_ill    = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (iclass == C_LW) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end else if (tmo_last) begin
          next_state = S_TRAP;
          set_tmo    = 1'b1;
        end else begin
          next_state = S_MEM;
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_TRAP;
        set_ill    = 1'b1;
      end
    endcase
  end

  // Datapath control outputs for the current state.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wb_sel    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctr   = ALU_ADD;
    ext_ctr   = 2'b00;
    npc_sel   = 2'b00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    trap      = 1'b0;
    if (!reset) begin
      trap = 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            ir_write = 1'b0;
            pc_write = 1'b0;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          ext_ctr   = 2'b01;
        end
        S_EXEC: begin
          case (iclass)
            C_RALU: begin
              alu_src_a = 1'b1;
              alu_ctr   = r_alu_op(func);
            end
            C_ORI: begin
              alu_src_b = 2'b10;
              alu_ctr   = ALU_OR;
            end
            C_LUI: begin
              alu_src_b = 2'b10;
              ext_ctr   = 2'b10;
              alu_ctr   = ALU_PASS;
            end
            C_LW, C_SW: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              ext_ctr   = 2'b01;
            end
            C_BEQ: begin
              alu_src_a = 1'b1;
              alu_ctr   = ALU_SUB;
              npc_sel   = 2'b01;
              pc_write  = zero;
            end
            C_J: begin
              npc_sel  = 2'b10;
              pc_write = 1'b1;
            end
            C_JAL: begin
              npc_sel   = 2'b10;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              reg_dst   = 2'b10;
              wb_sel    = 2'b10;
            end
            C_JR: begin
              npc_sel  = 2'b11;
              pc_write = 1'b1;
            end
            default: begin
              pc_write = 1'b0;
            end
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (iclass == C_SW);
        end
        S_WB: begin
          reg_write = 1'b1;
          case (iclass)
            C_RALU:  reg_dst = 2'b01;
            C_LW:    wb_sel  = 2'b01;
            default: reg_dst = 2'b00;
          endcase
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          trap = 1'b0;
        end
      endcase
    end
  end

  // Memory wait counter: restarts on entry to FETCH/MEM or any acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (mem_ready || mem_entry) begin
      tmo_cnt <= '0;
    end else if (mem_wait) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  // Trap cause: captured on the cycle the controller halts, then held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_reg <= 2'b00;
    end else if (set_ill) begin
      cause_reg <= CAUSE_ILL;
    end else if (set_tmo) begin
      cause_reg <= CAUSE_TMO;
    end else begin
      cause_reg <= cause_reg;
    end
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end else begin
      instret <= instret;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl (CNT_W=3, MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mips_mc_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  logic             clk;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       wb_sel;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [3:0]       alu_ctr;
  logic [1:0]       ext_ctr;
  logic [1:0]       npc_sel;
  logic             mem_req;
  logic             mem_we;
  logic             trap;
  logic [1:0]       cause;
  logic [CNT_W-1:0] instret;

  logic [22:0]      ctl;
  int               n_chk;
  int               n_fail;
  logic [CNT_W-1:0] exp_ret;
  logic [22:0]      e_fr, e_fw, e_dec, e_rst;

  mips_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
    .ext_ctr(ext_ctr), .npc_sel(npc_sel), .mem_req(mem_req),
    .mem_we(mem_we), .trap(trap), .cause(cause), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {pc_write, ir_write, reg_write, reg_dst, wb_sel, alu_src_a,
                alu_src_b, alu_ctr, ext_ctr, npc_sel, mem_req, mem_we, trap, cause};

  // Field order: pc ir rw rdst wbs asa asb alu ext npc mreq mwe trap cause
  function automatic logic [22:0] exp_ctl(
    input logic pc, input logic ir, input logic rw, input logic [1:0] rdst,
    input logic [1:0] wbs, input logic asa, input logic [1:0] asb,
    input logic [3:0] alu, input logic [1:0] ext, input logic [1:0] npc,
    input logic mrq, input logic mwe, input logic trp, input logic [1:0] cs);
    return {pc, ir, rw, rdst, wbs, asa, asb, alu, ext, npc, mrq, mwe, trp, cs};
  endfunction

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; op = 6'b000000; func = 6'b100001;
    for (int i = 0; i < 2; i++) begin
      #1; n_chk++;
      if (ctl !== e_rst) begin n_fail++; $display("FAIL reset_ctl_c%0d got=%h want=%h", i, ctl, e_rst); end
      n_chk++;
      if (instret !== 3'd0) begin n_fail++; $display("FAIL reset_instret got=%0d want=0", instret); end
      @(negedge clk);
    end
    reset = 1'b1; exp_ret = '0;
  endtask

  task automatic test_addu();
    logic [22:0] e [4];
    e[0] = e_fr; e[1] = e_dec;
    e[2] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b0,2'b00);
    e[3] = exp_ctl(1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b0,2'b00);
    op = 6'b000000; func = 6'b100001; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; n_chk++;
      if (ctl !== e[i]) begin n_fail++; $display("FAIL addu_c%0d got=%h want=%h", i, ctl, e[i]); end
      @(negedge clk);
    end
    exp_ret = exp_ret + 3'd1;
    #1; n_chk++;
    if (instret !== exp_ret) begin n_fail++; $display("FAIL addu_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_lw();
    logic [22:0] e [8];
    logic        r [8];
    e[0] = e_fr; e[1] = e_dec;
    e[2] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,4'b0000,2'b01,2'b00,1'b0,1'b0,1'b0,2'b00);
    for (int i = 3; i < 7; i++)
      e[i] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b1,1'b0,1'b0,2'b00);
    e[7] = exp_ctl(1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b0,2'b00);
    r[0] = 1'b1; r[1] = 1'b1; r[2] = 1'b1; r[3] = 1'b0;
    r[4] = 1'b0; r[5] = 1'b0; r[6] = 1'b1; r[7] = 1'b1;
    op = 6'b100011; func = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1; n_chk++;
      if (ctl !== e[i]) begin n_fail++; $display("FAIL lw_c%0d got=%h want=%h", i, ctl, e[i]); end
      @(negedge clk);
    end
    exp_ret = exp_ret + 3'd1;
    mem_ready = 1'b1;
    #1; n_chk++;
    if (instret !== exp_ret) begin n_fail++; $display("FAIL lw_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_beq();
    logic [22:0] e [3];
    for (int z = 1; z >= 0; z--) begin
      e[0] = e_fr; e[1] = e_dec;
      e[2] = exp_ctl(z[0],1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,4'b0001,2'b00,2'b01,1'b0,1'b0,1'b0,2'b00);
      op = 6'b000100; func = 6'b000000; zero = z[0]; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1; n_chk++;
        if (ctl !== e[i]) begin n_fail++; $display("FAIL beq_z%0d_c%0d got=%h want=%h", z, i, ctl, e[i]); end
        @(negedge clk);
      end
      exp_ret = exp_ret + 3'd1;
      #1; n_chk++;
      if (instret !== exp_ret) begin n_fail++; $display("FAIL beq_z%0d_instret got=%0d want=%0d", z, instret, exp_ret); end
    end
  endtask

  task automatic test_jal();
    logic [22:0] e [3];
    e[0] = e_fr; e[1] = e_dec;
    e[2] = exp_ctl(1'b1,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,4'b0000,2'b00,2'b10,1'b0,1'b0,1'b0,2'b00);
    op = 6'b000011; func = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; n_chk++;
      if (ctl !== e[i]) begin n_fail++; $display("FAIL jal_c%0d got=%h want=%h", i, ctl, e[i]); end
      @(negedge clk);
    end
    exp_ret = exp_ret + 3'd1;
    #1; n_chk++;
    if (instret !== exp_ret) begin n_fail++; $display("FAIL jal_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  // sw with three FETCH wait cycles: ready arrives exactly on the timeout edge.
  task automatic test_sw_fetch_wait();
    logic [22:0] e [7];
    logic        r [7];
    e[0] = e_fw; e[1] = e_fw; e[2] = e_fw; e[3] = e_fr; e[4] = e_dec;
    e[5] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,4'b0000,2'b01,2'b00,1'b0,1'b0,1'b0,2'b00);
    e[6] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b1,1'b1,1'b0,2'b00);
    r[0] = 1'b0; r[1] = 1'b0; r[2] = 1'b0; r[3] = 1'b1; r[4] = 1'b1; r[5] = 1'b1; r[6] = 1'b1;
    op = 6'b101011; func = 6'b000000; zero = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = r[i];
      #1; n_chk++;
      if (ctl !== e[i]) begin n_fail++; $display("FAIL sw_c%0d got=%h want=%h", i, ctl, e[i]); end
      @(negedge clk);
    end
    exp_ret = exp_ret + 3'd1;
    #1; n_chk++;
    if (instret !== exp_ret) begin n_fail++; $display("FAIL sw_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_ori_lui();
    logic [22:0] e [4];
    for (int k = 0; k < 2; k++) begin
      e[0] = e_fr; e[1] = e_dec;
      if (k == 0)
        e[2] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b10,4'b0010,2'b00,2'b00,1'b0,1'b0,1'b0,2'b00);
      else
        e[2] = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b10,4'b0101,2'b10,2'b00,1'b0,1'b0,1'b0,2'b00);
      e[3] = exp_ctl(1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b0,2'b00);
      op = (k == 0) ? 6'b001101 : 6'b001111; func = 6'b000000; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1; n_chk++;
        if (ctl !== e[i]) begin n_fail++; $display("FAIL imm%0d_c%0d got=%h want=%h", k, i, ctl, e[i]); end
        @(negedge clk);
      end
      exp_ret = exp_ret + 3'd1;
      #1; n_chk++;
      if (instret !== exp_ret) begin n_fail++; $display("FAIL imm%0d_instret got=%0d want=%0d", k, instret, exp_ret); end
    end
  endtask

  // Ninth retirement since reset: the 3-bit counter wraps to 1.
  task automatic test_jr_wrap();
    logic [22:0] e [3];
    e[0] = e_fr; e[1] = e_dec;
    e[2] = exp_ctl(1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b11,1'b0,1'b0,1'b0,2'b00);
    op = 6'b000000; func = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; n_chk++;
      if (ctl !== e[i]) begin n_fail++; $display("FAIL jr_c%0d got=%h want=%h", i, ctl, e[i]); end
      @(negedge clk);
    end
    exp_ret = exp_ret + 3'd1;
    #1; n_chk++;
    if (instret !== 3'd1) begin n_fail++; $display("FAIL wrap_instret got=%0d want=1", instret); end
  endtask

  task automatic test_mid_mem_reset();
    logic [22:0] e_mem;
    e_mem = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b1,1'b0,1'b0,2'b00);
    op = 6'b100011; func = 6'b000000; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1; n_chk++;
    if (ctl !== e_mem) begin n_fail++; $display("FAIL midrst_inmem got=%h want=%h", ctl, e_mem); end
    #2; reset = 1'b0;
    #1; n_chk++;
    if (ctl !== e_rst) begin n_fail++; $display("FAIL midrst_ctl got=%h want=%h", ctl, e_rst); end
    n_chk++;
    if (instret !== 3'd0) begin n_fail++; $display("FAIL midrst_instret got=%0d want=0", instret); end
    @(negedge clk);
    reset = 1'b1; exp_ret = '0;
    #1; n_chk++;
    if (ctl !== e_fw) begin n_fail++; $display("FAIL midrst_refetch got=%h want=%h", ctl, e_fw); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [22:0] e_trap;
    e_trap = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b1,2'b01);
    op = 6'b111111; func = 6'b000000; mem_ready = 1'b1;
    #1; n_chk++;
    if (ctl !== e_fr) begin n_fail++; $display("FAIL ill_fetch got=%h want=%h", ctl, e_fr); end
    @(negedge clk);
    #1; n_chk++;
    if (ctl !== e_dec) begin n_fail++; $display("FAIL ill_decode got=%h want=%h", ctl, e_dec); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1; n_chk++;
      if (ctl !== e_trap) begin n_fail++; $display("FAIL ill_trap_c%0d got=%h want=%h", i, ctl, e_trap); end
      @(negedge clk);
    end
    pulse_reset();
  endtask

  // Retire a j, then hold mem_ready low in FETCH until the timeout trap.
  task automatic test_timeout();
    logic [22:0] e_j, e_trap;
    e_j    = exp_ctl(1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b10,1'b0,1'b0,1'b0,2'b00);
    e_trap = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,4'b0000,2'b00,2'b00,1'b0,1'b0,1'b1,2'b10);
    op = 6'b000010; func = 6'b000000; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1; n_chk++;
    if (ctl !== e_j) begin n_fail++; $display("FAIL j_exec got=%h want=%h", ctl, e_j); end
    @(negedge clk);
    exp_ret = exp_ret + 3'd1;
    mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1; n_chk++;
      if (ctl !== e_fw) begin n_fail++; $display("FAIL tmo_wait_c%0d got=%h want=%h", i, ctl, e_fw); end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1; n_chk++;
      if (ctl !== e_trap) begin n_fail++; $display("FAIL tmo_trap_c%0d got=%h want=%h", i, ctl, e_trap); end
      n_chk++;
      if (instret !== exp_ret) begin n_fail++; $display("FAIL tmo_instret got=%0d want=%0d", instret, exp_ret); end
      @(negedge clk);
    end
    pulse_reset();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_ret = '0;
    reset = 1'b0; op = 6'b000000; func = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    e_rst = '0;
    e_fr  = exp_ctl(1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b01,4'b0000,2'b00,2'b00,1'b1,1'b0,1'b0,2'b00);
    e_fw  = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,4'b0000,2'b00,2'b00,1'b1,1'b0,1'b0,2'b00);
    e_dec = exp_ctl(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,4'b0000,2'b01,2'b00,1'b0,1'b0,1'b0,2'b00);
    @(negedge clk);
    test_reset();
    test_addu();
    test_lw();
    test_beq();
    test_jal();
    test_sw_fetch_wait();
    test_ori_lui();
    test_jr_wrap();
    test_mid_mem_reset();
    test_illegal();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
